uart0_rx_deframer: RTL and testbench

Receive deframer for the `uart0_rxd` pin. It synchronises the asynchronous serial line and recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) using a fixed clocks-per-bit divider. Each good byte goes to the on-chip consumer through a one-entry valid/ready holding register. It sits directly downstream of the `uart0_rxd` board pin, in parallel with the pin-level loopback logic, and is the first stage of the UART receive path.

---
 rtl/uart0_rx_deframer_if.sv | 21 ++
 rtl/uart0_rx_deframer.sv | 179 +++++++++++++++++
 tb/tb_uart0_rx_deframer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart0_rx_deframer_if.sv
// Receive-side valid/ready handshake between the UART deframer and its
// on-chip consumer. The deframer is the master (it owns data/valid).
`timescale 1ns/1ps

interface uart0_rx_deframer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart0_rx_deframer.sv
// UART 8N1 receive deframer for the uart0_rxd pin.
// Synchronises the raw line, recovers start/data/stop bits with a fixed
// clocks-per-bit divider and hands each good byte to the consumer through a
// one-entry valid/ready holding register. CLKS_PER_BIT must be >= 4 and even.
`timescale 1ns/1ps

module uart0_rx_deframer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                       system_clk,
  input  logic                       reset,
  input  logic                       uart0_rxd,
  uart0_rx_deframer_if.master        rx_if,
  output logic                       rx_busy,
  output logic                       frame_err,
  output logic                       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  // Sample points: half a bit into the start bit, then one full bit apart.
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  logic          sync1_q, sync2_q;
  logic          rxd_s;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          fe_q, fe_d;
  logic          ov_q, ov_d;
  logic          load;

  assign rxd_s = sync2_q;

  // Two-flop synchroniser; flops reset high so the line looks idle.
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep this a true two-stage pipeline;
      // blocking ones would collapse both flops into a single stage.
      sync1_q <= uart0_rxd;
      sync2_q <= sync1_q;
    end
  end

  // Next-state logic: bit timing FSM plus holding-register update.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
    load    = 1'b0;

    // Consumer handshake empties the holding register unless a load refills it.
    if (valid_q && rx_if.rx_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxd_s) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          // A line that is high again at mid start bit was a glitch.
          state_d = rxd_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxd_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxd_s) begin
            load    = 1'b1;
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // A break holds the line low; wait it out so it reports only once.
      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rxd_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A load overwrites the holding register; it only counts as an overrun
    // if the previous byte was not taken in this same cycle.
    if (load) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      ov_d    = valid_q && !rx_if.rx_ready;
    end
  end

  // State registers; everything returns to idle/empty on reset.
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      // NOTE: the shift register is reset too; it is only eight flops and a
      // known value keeps a truncated frame from leaking stale bits.
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  // All outputs come straight from flops.
  assign rx_if.rx_data  = data_q;
  assign rx_if.rx_valid = valid_q;
  assign rx_busy        = (state_q != S_IDLE);
  assign frame_err      = fe_q;
  assign overrun        = ov_q;

endmodule

// File: tb/tb_uart0_rx_deframer.sv
// Directed bench for uart0_rx_deframer at 16 clocks per bit.
`timescale 1ns/1ps

module tb_uart0_rx_deframer;

  localparam int N = 16;

  logic system_clk;
  logic reset;
  logic uart0_rxd;
  logic rx_busy;
  logic frame_err;
  logic overrun;

  uart0_rx_deframer_if rx_if ();

  uart0_rx_deframer #(
    .CLKS_PER_BIT (N)
  ) dut (
    .system_clk (system_clk),
    .reset      (reset),
    .uart0_rxd  (uart0_rxd),
    .rx_if      (rx_if),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  initial system_clk = 1'b0;
  always #5 system_clk = ~system_clk;

  // Rising-edge count, used to time events relative to stimulus.
  int cyc = 0;
  always @(posedge system_clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  int   n_rise = 0, n_vcyc = 0, n_fe = 0, n_ov = 0, n_busy_rise = 0;
  int   n_fe_long = 0, n_ov_long = 0, rise_cyc = 0;
  logic valid_p = 1'b0, busy_p = 1'b0, fe_p = 1'b0, ov_p = 1'b0;

  always @(negedge system_clk) begin
    if (rx_if.rx_valid && !valid_p) begin
      n_rise++;
      rise_cyc = cyc;
    end
    if (rx_if.rx_valid)       n_vcyc++;
    if (frame_err)            n_fe++;
    if (overrun)              n_ov++;
    if (rx_busy && !busy_p)   n_busy_rise++;
    if (frame_err && fe_p)    n_fe_long++;
    if (overrun && ov_p)      n_ov_long++;
    valid_p = rx_if.rx_valid;
    busy_p  = rx_busy;
    fe_p    = frame_err;
    ov_p    = overrun;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next falling edge.
  task automatic tick();
    @(negedge system_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart0_rxd = 1'b0;
    repeat (N) tick();
    for (int i = 0; i < 8; i++) begin
      uart0_rxd = b[i];
      repeat (N) tick();
    end
    uart0_rxd = stop_bit;
    repeat (N) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "bench timeout");
  end

  int k, b_rise, b_vcyc, b_fe, b_ov, b_busy;

  task automatic snap();
    b_rise = n_rise;
    b_vcyc = n_vcyc;
    b_fe   = n_fe;
    b_ov   = n_ov;
    b_busy = n_busy_rise;
  endtask

  initial begin
    reset          = 1'b1;
    uart0_rxd      = 1'b1;
    rx_if.rx_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    // Reset state.
    check("rst_valid", rx_if.rx_valid, 0);
    check("rst_data",  rx_if.rx_data, 8'h00);
    check("rst_busy",  rx_busy, 0);
    check("rst_fe",    frame_err, 0);
    check("rst_ov",    overrun, 0);

    // Single byte 0xA5, consumer always ready. Pin goes low before edge k+1
    // (t0); valid must rise at t0+155 +/-1, i.e. k+155..k+157.
    rx_if.rx_ready = 1'b1;
    snap();
    k = cyc;
    send_byte(8'hA5, 1'b1);
    repeat (N) tick();
    check("a5_rise_cnt", n_rise - b_rise, 1);
    check("a5_latency_ok", (rise_cyc - k >= 155) && (rise_cyc - k <= 157), 1);
    check("a5_valid_width", n_vcyc - b_vcyc, 1);
    check("a5_fe", n_fe - b_fe, 0);
    check("a5_ov", n_ov - b_ov, 0);

    // Back-to-back 0x00, 0xFF, 0x3C with backpressure.
    rx_if.rx_ready = 1'b0;
    snap();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    check("b2b_ov_after2", n_ov - b_ov, 1);
    check("b2b_data_ff",   rx_if.rx_data, 8'hFF);
    send_byte(8'h3C, 1'b1);
    check("b2b_ov_after3", n_ov - b_ov, 2);
    check("b2b_data_3c",   rx_if.rx_data, 8'h3C);
    check("b2b_valid",     rx_if.rx_valid, 1);
    rx_if.rx_ready = 1'b1;
    tick();
    check("b2b_cleared",   rx_if.rx_valid, 0);

    // Framing error followed by a 40-bit break, then a good byte.
    snap();
    send_byte(8'h55, 1'b0);
    repeat (40 * N) tick();
    uart0_rxd = 1'b1;
    repeat (2 * N) tick();
    check("brk_fe_once",  n_fe - b_fe, 1);
    check("brk_no_valid", n_rise - b_rise, 0);
    rx_if.rx_ready = 1'b0;
    send_byte(8'h12, 1'b1);
    check("brk_data_12",  rx_if.rx_data, 8'h12);
    check("brk_valid_12", rx_if.rx_valid, 1);
    rx_if.rx_ready = 1'b1;
    tick();

    // Three-cycle low glitch on an idle line.
    snap();
    uart0_rxd = 1'b0;
    repeat (3) tick();
    uart0_rxd = 1'b1;
    repeat (N / 2 + 3) tick();
    check("gl_busy_low",  rx_busy, 0);
    check("gl_seen",      n_busy_rise - b_busy, 1);
    check("gl_no_valid",  n_rise - b_rise, 0);
    check("gl_no_fe",     n_fe - b_fe, 0);
    check("gl_no_ov",     n_ov - b_ov, 0);

    // Handshake exactly on the load edge (k+155 for a frame started at k).
    rx_if.rx_ready = 1'b0;
    send_byte(8'h11, 1'b1);
    check("hs_pre_data",  rx_if.rx_data, 8'h11);
    check("hs_pre_valid", rx_if.rx_valid, 1);
    snap();
    fork
      send_byte(8'h22, 1'b1);
      begin
        repeat (154) tick();
        rx_if.rx_ready = 1'b1;
        tick();
        rx_if.rx_ready = 1'b0;
        check("hs_valid", rx_if.rx_valid, 1);
        check("hs_data",  rx_if.rx_data, 8'h22);
      end
    join
    check("hs_no_ov",     n_ov - b_ov, 0);
    check("hs_no_drop",   n_rise - b_rise, 0);
    rx_if.rx_ready = 1'b1;
    tick();

    // Reset asserted in the middle of data bit 4 of 0x99, released during
    // its stop bit while the line is high.
    rx_if.rx_ready = 1'b0;
    snap();
    fork
      send_byte(8'h99, 1'b1);
      begin
        repeat (88) tick();
        reset = 1'b1;
        #1;
        check("mr_valid", rx_if.rx_valid, 0);
        check("mr_data",  rx_if.rx_data, 8'h00);
        check("mr_busy",  rx_busy, 0);
        check("mr_fe",    frame_err, 0);
        check("mr_ov",    overrun, 0);
        repeat (64) tick();
        reset = 1'b0;
      end
    join
    repeat (2 * N) tick();
    check("mr_no_rise",  n_rise - b_rise, 0);
    check("mr_idle",     rx_if.rx_valid, 0);
    send_byte(8'h42, 1'b1);
    check("mr_data_42",  rx_if.rx_data, 8'h42);
    check("mr_valid_42", rx_if.rx_valid, 1);
    check("mr_no_fe",    n_fe - b_fe, 0);

    // Status pulses never last longer than one cycle.
    check("fe_pulse_width", n_fe_long, 0);
    check("ov_pulse_width", n_ov_long, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
